// File: rtl/harvos_dma_fw_pkg.sv
// harvos_dma_fw_pkg: FSM encoding, config word map and control bit positions
// shared by the multi-region DMA firewall and its per-region sub-module.
package harvos_dma_fw_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_FAULT = 2'd2
   } fw_state_e;

   localparam logic [5:0] CTRL  = 6'd0;
   localparam logic [5:0] ROM   = 6'd1;
   localparam logic [5:0] FADDR = 6'd2;
   localparam logic [5:0] FINFO = 6'd3;

   localparam int unsigned REGION_BASE   = 4;
   localparam int unsigned REGION_STRIDE = 3;

   localparam int unsigned CTRL_LOCK    = 0;
   localparam int unsigned CTRL_CLR     = 1;
   localparam int unsigned RCTRL_EN     = 0;
   localparam int unsigned RCTRL_BLK_RD = 1;
   localparam int unsigned RCTRL_BLK_WR = 2;

endpackage

// File: rtl/harvos_dma_fw_region.sv
// harvos_dma_fw_region: one protected base/mask region with its own control
// register and the combinational hit/block decision for the current DMA access.
module harvos_dma_fw_region
   import harvos_dma_fw_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_base,
   input  logic        wr_mask,
   input  logic        wr_ctrl,
   input  logic [31:0] wdata,
   input  logic [31:0] addr,
   input  logic        we,
   output logic [31:0] base,
   output logic [31:0] mask,
   output logic [2:0]  ctrl,
   output logic        block
);

   logic [31:0] base_q, base_d;
   logic [31:0] mask_q, mask_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic        hit;

   always_comb begin
      base_d = wr_base ? wdata : base_q;
      mask_d = wr_mask ? wdata : mask_q;
      ctrl_d = wr_ctrl ? wdata[2:0] : ctrl_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q <= '0;
         mask_q <= '1;
         ctrl_q <= '0;
      end else begin
         base_q <= base_d;
         mask_q <= mask_d;
         ctrl_q <= ctrl_d;
      end
   end

   always_comb begin
      hit   = ctrl_q[RCTRL_EN] && ((addr & ~mask_q) == base_q);
      block = hit && (we ? ctrl_q[RCTRL_BLK_WR] : ctrl_q[RCTRL_BLK_RD]);
   end

   assign base = base_q;
   assign mask = mask_q;
   assign ctrl = ctrl_q;

endmodule

// File: rtl/harvos_dma_firewall_mr.sv
// harvos_dma_firewall_mr: multi-region DMA firewall with fault log and single-outstanding
// forwarding. Define HARVOS_DMA_FW_TIMEOUT_EN to add a response timeout in WAIT.
module harvos_dma_firewall_mr
   import harvos_dma_fw_pkg::*;
#(
   parameter int unsigned NREG      = 4,
   parameter int unsigned ROM_BYTES = 16384,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_en,
   input  logic        cfg_we,
   input  logic [5:0]  cfg_addr,
   input  logic [31:0] cfg_wdata,
   output logic [31:0] cfg_rdata,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [3:0]  dma_be,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   output logic [31:0] dma_rdata,
   output logic        dma_done,
   output logic        dma_fault,
   output logic        fw_req,
   output logic        fw_we,
   output logic [3:0]  fw_be,
   output logic [31:0] fw_addr,
   output logic [31:0] fw_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_rvalid,
   input  logic        m_fault,
   output logic        fault_irq
);

   fw_state_e        state_q, state_d;
   logic             fw_req_q, fw_req_d, fw_we_q, fw_we_d;
   logic [3:0]       fw_be_q, fw_be_d;
   logic [31:0]      fw_addr_q, fw_addr_d, fw_wdata_q, fw_wdata_d;
   logic             done_q, done_d, dfault_q, dfault_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             lock_q, lock_d;
   logic [31:0]      rom_q, rom_d;
   logic             flog_v_q, flog_v_d, flog_we_q, flog_we_d;
   logic [31:0]      flog_addr_q, flog_addr_d;
   logic [CNT_W-1:0] flog_cnt_q, flog_cnt_d;
   logic             ev, ev_we;
   logic [31:0]      ev_addr;
   logic             cfg_wr, cfg_wr_ok, clr, blk, finfo_to;
`ifdef HARVOS_DMA_FW_TIMEOUT_EN
   logic [15:0]      to_cnt_q, to_cnt_d;
   logic             ev_to, flog_to_q, flog_to_d;
`endif

   logic [NREG-1:0][31:0] r_base, r_mask;
   logic [NREG-1:0][2:0]  r_ctrl;
   logic [NREG-1:0]       r_blk;

   assign cfg_wr    = cfg_en && cfg_we;
   assign cfg_wr_ok = cfg_wr && !lock_q;
   assign clr       = cfg_wr && (cfg_addr == CTRL) && cfg_wdata[CTRL_CLR];

   for (genvar i = 0; i < NREG; i++) begin : g_region
      localparam logic [5:0] IDX = 6'(REGION_BASE + REGION_STRIDE * i);
      harvos_dma_fw_region u_region (
         .clk     (clk),
         .rst_n   (rst_n),
         .wr_base (cfg_wr_ok && (cfg_addr == IDX)),
         .wr_mask (cfg_wr_ok && (cfg_addr == IDX + 6'd1)),
         .wr_ctrl (cfg_wr_ok && (cfg_addr == IDX + 6'd2)),
         .wdata   (cfg_wdata),
         .addr    (dma_addr),
         .we      (dma_we),
         .base    (r_base[i]),
         .mask    (r_mask[i]),
         .ctrl    (r_ctrl[i]),
         .block   (r_blk[i])
      );
   end

   assign blk = (dma_we && (dma_addr < rom_q)) || (|r_blk);

   always_comb begin
      state_d    = state_q;
      fw_req_d   = 1'b0;
      fw_we_d    = fw_we_q;
      fw_be_d    = fw_be_q;
      fw_addr_d  = fw_addr_q;
      fw_wdata_d = fw_wdata_q;
      done_d     = 1'b0;
      dfault_d   = 1'b0;
      rdata_d    = '0;
      ev         = 1'b0;
      ev_we      = fw_we_q;
      ev_addr    = fw_addr_q;
`ifdef HARVOS_DMA_FW_TIMEOUT_EN
      to_cnt_d   = '0;
      ev_to      = 1'b0;
`endif
      // Completion is issued on the transition, so done is already high while the
      // master still holds dma_req; the !done_q guard keeps that from re-launching.
      unique case (state_q)
         S_IDLE: begin
            if (dma_req && !done_q) begin
               if (blk) begin
                  state_d  = S_FAULT;
                  done_d   = 1'b1;
                  dfault_d = 1'b1;
                  ev       = 1'b1;
                  ev_we    = dma_we;
                  ev_addr  = dma_addr;
               end else begin
                  state_d    = S_WAIT;
                  fw_req_d   = 1'b1;
                  fw_we_d    = dma_we;
                  fw_be_d    = dma_be;
                  fw_addr_d  = dma_addr;
                  fw_wdata_d = dma_wdata;
               end
            end
         end
         S_WAIT: begin
            if (m_rvalid) begin
               state_d  = S_IDLE;
               done_d   = 1'b1;
               dfault_d = m_fault;
               rdata_d  = fw_we_q ? '0 : m_rdata;
               ev       = m_fault;
            end
`ifdef HARVOS_DMA_FW_TIMEOUT_EN
            else if (to_cnt_q == 16'(TIMEOUT - 1)) begin
               state_d  = S_FAULT;
               done_d   = 1'b1;
               dfault_d = 1'b1;
               ev       = 1'b1;
               ev_to    = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + 16'd1;
            end
`endif
         end
         S_FAULT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         fw_req_q   <= 1'b0;
         fw_we_q    <= 1'b0;
         fw_be_q    <= '0;
         fw_addr_q  <= '0;
         fw_wdata_q <= '0;
         done_q     <= 1'b0;
         dfault_q   <= 1'b0;
         rdata_q    <= '0;
`ifdef HARVOS_DMA_FW_TIMEOUT_EN
         to_cnt_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         fw_req_q   <= fw_req_d;
         fw_we_q    <= fw_we_d;
         fw_be_q    <= fw_be_d;
         fw_addr_q  <= fw_addr_d;
         fw_wdata_q <= fw_wdata_d;
         done_q     <= done_d;
         dfault_q   <= dfault_d;
         rdata_q    <= rdata_d;
`ifdef HARVOS_DMA_FW_TIMEOUT_EN
         to_cnt_q   <= to_cnt_d;
`endif
      end
   end

   // Clear is applied before the event so a same-cycle fault starts a fresh log.
   always_comb begin
      lock_d      = lock_q | (cfg_wr_ok && (cfg_addr == CTRL) && cfg_wdata[CTRL_LOCK]);
      rom_d       = (cfg_wr_ok && (cfg_addr == ROM)) ? cfg_wdata : rom_q;
      flog_v_d    = flog_v_q;
      flog_we_d   = flog_we_q;
      flog_addr_d = flog_addr_q;
      flog_cnt_d  = flog_cnt_q;
`ifdef HARVOS_DMA_FW_TIMEOUT_EN
      flog_to_d   = flog_to_q;
`endif
      if (clr) begin
         flog_v_d    = 1'b0;
         flog_we_d   = 1'b0;
         flog_addr_d = '0;
         flog_cnt_d  = '0;
`ifdef HARVOS_DMA_FW_TIMEOUT_EN
         flog_to_d   = 1'b0;
`endif
      end
      if (ev) begin
         if (!flog_v_d) begin
            flog_v_d    = 1'b1;
            flog_we_d   = ev_we;
            flog_addr_d = ev_addr;
`ifdef HARVOS_DMA_FW_TIMEOUT_EN
            flog_to_d   = ev_to;
`endif
         end
         if (flog_cnt_d != '1) flog_cnt_d = flog_cnt_d + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q      <= 1'b0;
         rom_q       <= 32'(ROM_BYTES);
         flog_v_q    <= 1'b0;
         flog_we_q   <= 1'b0;
         flog_addr_q <= '0;
         flog_cnt_q  <= '0;
`ifdef HARVOS_DMA_FW_TIMEOUT_EN
         flog_to_q   <= 1'b0;
`endif
      end else begin
         lock_q      <= lock_d;
         rom_q       <= rom_d;
         flog_v_q    <= flog_v_d;
         flog_we_q   <= flog_we_d;
         flog_addr_q <= flog_addr_d;
         flog_cnt_q  <= flog_cnt_d;
`ifdef HARVOS_DMA_FW_TIMEOUT_EN
         flog_to_q   <= flog_to_d;
`endif
      end
   end

`ifdef HARVOS_DMA_FW_TIMEOUT_EN
   assign finfo_to = flog_to_q;
`else
   assign finfo_to = 1'b0;
`endif

   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         CTRL:    cfg_rdata = {31'd0, lock_q};
         ROM:     cfg_rdata = rom_q;
         FADDR:   cfg_rdata = flog_addr_q;
         FINFO:   cfg_rdata = {16'(flog_cnt_q), 13'd0, finfo_to, flog_we_q, flog_v_q};
         default: cfg_rdata = '0;
      endcase
      for (int unsigned i = 0; i < NREG; i++) begin
         if ({26'd0, cfg_addr} == REGION_BASE + REGION_STRIDE * i)     cfg_rdata = r_base[i];
         if ({26'd0, cfg_addr} == REGION_BASE + REGION_STRIDE * i + 1) cfg_rdata = r_mask[i];
         if ({26'd0, cfg_addr} == REGION_BASE + REGION_STRIDE * i + 2) cfg_rdata = {29'd0, r_ctrl[i]};
      end
   end

   assign dma_rdata = rdata_q;
   assign dma_done  = done_q;
   assign dma_fault = dfault_q;
   assign fw_req    = fw_req_q;
   assign fw_we     = fw_we_q;
   assign fw_be     = fw_be_q;
   assign fw_addr   = fw_addr_q;
   assign fw_wdata  = fw_wdata_q;
   assign fault_irq = flog_v_q;

endmodule

// File: tb/tb_harvos_dma_firewall_mr.sv
// tb_harvos_dma_firewall_mr: table vectors, hand sequences and random accesses
// checked against a region/log reference model kept in the bench.
module tb_harvos_dma_firewall_mr;

   localparam int NREG       = 4;
   localparam int TB_CNT_W   = 2;
   localparam int TB_TIMEOUT = 8;
   localparam int CNT_MAX    = (1 << TB_CNT_W) - 1;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        cfg_en = 0, cfg_we = 0;
   logic [5:0]  cfg_addr = 0;
   logic [31:0] cfg_wdata = 0, cfg_rdata;
   logic        dma_req = 0, dma_we = 0;
   logic [3:0]  dma_be = 0;
   logic [31:0] dma_addr = 0, dma_wdata = 0, dma_rdata;
   logic        dma_done, dma_fault, fw_req, fw_we, fault_irq;
   logic [3:0]  fw_be;
   logic [31:0] fw_addr, fw_wdata;
   logic [31:0] m_rdata = 0;
   logic        m_rvalid = 0, m_fault = 0;

   int n_tests = 0, n_fail = 0;

   // reference model state
   logic [31:0] m_rom;
   logic [31:0] m_base [NREG];
   logic [31:0] m_mask [NREG];
   logic [2:0]  m_ctrl [NREG];
   logic        m_lock, m_fv, m_fwe, m_fto;
   logic [31:0] m_faddr;
   int          m_fcnt;

   harvos_dma_firewall_mr #(
      .NREG(NREG), .ROM_BYTES(16384), .CNT_W(TB_CNT_W), .TIMEOUT(TB_TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .dma_req(dma_req), .dma_we(dma_we),
      .dma_be(dma_be), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rdata(dma_rdata),
      .dma_done(dma_done), .dma_fault(dma_fault), .fw_req(fw_req), .fw_we(fw_we),
      .fw_be(fw_be), .fw_addr(fw_addr), .fw_wdata(fw_wdata), .m_rdata(m_rdata),
      .m_rvalid(m_rvalid), .m_fault(m_fault), .fault_irq(fault_irq)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   task automatic model_clear();
      m_fv = 0; m_fwe = 0; m_fto = 0; m_faddr = 0; m_fcnt = 0;
   endtask

   task automatic model_reset();
      m_rom = 32'd16384; m_lock = 0;
      for (int r = 0; r < NREG; r++) begin
         m_base[r] = '0; m_mask[r] = '1; m_ctrl[r] = '0;
      end
      model_clear();
   endtask

   task automatic model_fault(input logic [31:0] a, input logic we, input logic to);
      if (!m_fv) begin
         m_fv = 1; m_faddr = a; m_fwe = we; m_fto = to;
      end
      if (m_fcnt < CNT_MAX) m_fcnt++;
   endtask

   function automatic logic model_block(input logic we, input logic [31:0] a);
      logic b;
      b = we && (a < m_rom);
      for (int r = 0; r < NREG; r++)
         if (m_ctrl[r][0] && ((a & ~m_mask[r]) == m_base[r]) && (we ? m_ctrl[r][2] : m_ctrl[r][1]))
            b = 1'b1;
      return b;
   endfunction

   function automatic logic [31:0] model_finfo();
      return {16'(m_fcnt), 13'd0, m_fto, m_fwe, m_fv};
   endfunction

   task automatic cfg_write(input int a, input logic [31:0] d);
      int idx;
      @(negedge clk);
      cfg_en = 1; cfg_we = 1; cfg_addr = 6'(a); cfg_wdata = d;
      @(negedge clk);
      cfg_en = 0; cfg_we = 0;
      if (a == 0) begin
         if (d[1]) model_clear();
         if (d[0]) m_lock = 1;
      end else if (!m_lock) begin
         if (a == 1) m_rom = d;
         else if (a >= 4 && a < 4 + 3 * NREG) begin
            idx = a - 4;
            case (idx % 3)
               0: m_base[idx / 3] = d;
               1: m_mask[idx / 3] = d;
               default: m_ctrl[idx / 3] = d[2:0];
            endcase
         end
      end
   endtask

   task automatic cfg_read(input int a, output logic [31:0] d);
      @(negedge clk);
      cfg_en = 1; cfg_we = 0; cfg_addr = 6'(a);
      #1 d = cfg_rdata;
      cfg_en = 0;
   endtask

   task automatic check_log(input string nm);
      logic [31:0] d;
      cfg_read(2, d); check({nm, "_faddr"}, d, m_faddr);
      cfg_read(3, d); check({nm, "_finfo"}, d, model_finfo());
      check({nm, "_irq"}, {31'd0, fault_irq}, {31'd0, m_fv});
   endtask

   // lat < 0: the bus never answers
   task automatic run_access(input string nm, input logic we, input logic [31:0] addr,
                             input int lat, input logic mf, input logic [31:0] mrd,
                             output logic a_fault);
      logic        exp_blk, got_done, fwd;
      logic [31:0] got_rd, wd, exp_rd;
      logic [3:0]  be;
      int          cyc, rc, exp_cyc;
      exp_blk = model_block(we, addr);
      wd = $urandom; be = 4'($urandom);
      @(negedge clk);
      dma_req = 1; dma_we = we; dma_be = be; dma_addr = addr; dma_wdata = wd;
      got_done = 0; fwd = 0; cyc = 0; rc = -1; got_rd = 0; a_fault = 0;
      while (!got_done && cyc < 300) begin
         @(negedge clk);
         cyc++;
         m_rvalid = 0; m_fault = 0; m_rdata = $urandom;
         if (fw_req) begin
            fwd = 1;
            check({nm, "_fwaddr"}, fw_addr, addr);
            check({nm, "_fwctl"}, {27'd0, fw_we, fw_be}, {27'd0, we, be});
            check({nm, "_fwdata"}, fw_wdata, wd);
            rc = lat;
         end
         if (dma_done) begin
            got_done = 1; a_fault = dma_fault; got_rd = dma_rdata;
         end else if (rc == 0) begin
            m_rvalid = 1; m_rdata = mrd; m_fault = mf; rc = -1;
         end else if (rc > 0) rc--;
      end
      m_rvalid = 0; m_fault = 0;
      check({nm, "_done"}, {31'd0, got_done}, 32'd1);
      check({nm, "_fwd"}, {31'd0, fwd}, {31'd0, !exp_blk});
      exp_cyc = exp_blk ? 1 : (lat < 0 ? TB_TIMEOUT + 1 : lat + 2);
      check({nm, "_lat"}, cyc, exp_cyc);
      check({nm, "_fault"}, {31'd0, a_fault}, {31'd0, exp_blk || lat < 0 || mf});
      exp_rd = (exp_blk || we || lat < 0) ? 32'd0 : mrd;
      check({nm, "_rdata"}, got_rd, exp_rd);
      if (exp_blk || lat < 0 || mf) model_fault(addr, we, !exp_blk && lat < 0);
      // master drops dma_req only after seeing done; nothing may restart
      @(negedge clk);
      dma_req = 0;
      check({nm, "_norestart"}, {30'd0, fw_req, dma_done}, 32'd0);
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      int          lat;
      logic [31:0] mrd;
      logic        exp_fault;
   } vec_t;

   vec_t vt[10];

   initial begin
      logic [31:0] d;
      logic        f, seen;
      int          k, sel, r;
      logic [31:0] a, msk;

      model_reset();
      repeat (2) @(negedge clk);
      check("rst_ctl", {23'd0, dma_done, dma_fault, fw_req, fw_we, fw_be, fault_irq}, 32'd0);
      check("rst_rdata", dma_rdata, 32'd0);
      rst_n = 1;
      cfg_read(1, d); check("rst_rom", d, 32'h0000_4000);
      cfg_read(0, d); check("rst_control", d, 32'd0);
      cfg_read(3, d); check("rst_finfo", d, 32'd0);
      for (int i = 0; i < NREG; i++) begin
         cfg_read(4 + 3 * i, d); check("rst_base", d, 32'd0);
         cfg_read(5 + 3 * i, d); check("rst_mask", d, 32'hFFFF_FFFF);
         cfg_read(6 + 3 * i, d); check("rst_rctrl", d, 32'd0);
      end
      cfg_read(60, d); check("unmapped_rd", d, 32'd0);

      // table-driven decisions
      cfg_write(10, 32'h8000_0000); cfg_write(11, 32'h0000_0FFF); cfg_write(12, 32'h5);
      cfg_write(4, 32'h9000_0000);  cfg_write(5, 32'h0000_00FF);  cfg_write(6, 32'h3);
      cfg_write(60, 32'hFFFF_FFFF);
      cfg_read(12, d); check("region2_ctrl", d, 32'h5);
      vt[0] = '{1'b1, 32'h0000_0100, 0, 32'h0,         1'b1};
      vt[1] = '{1'b0, 32'h0000_0100, 1, 32'h1234_5678, 1'b0};
      vt[2] = '{1'b1, 32'h0000_3FFC, 0, 32'h0,         1'b1};
      vt[3] = '{1'b1, 32'h0000_4000, 2, 32'h0,         1'b0};
      vt[4] = '{1'b0, 32'h8000_0010, 3, 32'hDEAD_BEEF, 1'b0};
      vt[5] = '{1'b1, 32'h8000_0010, 0, 32'h0,         1'b1};
      vt[6] = '{1'b1, 32'h8000_1010, 0, 32'h0,         1'b0};
      vt[7] = '{1'b0, 32'h9000_00FC, 0, 32'h0,         1'b1};
      vt[8] = '{1'b1, 32'h9000_00FC, 1, 32'h0,         1'b0};
      vt[9] = '{1'b0, 32'h9000_0100, 0, 32'hCAFE_F00D, 1'b0};
      for (int i = 0; i < 10; i++) begin
         run_access($sformatf("vec%0d", i), vt[i].we, vt[i].addr, vt[i].lat, 1'b0, vt[i].mrd, f);
         check($sformatf("vec%0d_tbl", i), {31'd0, f}, {31'd0, vt[i].exp_fault});
      end
      check_log("tbl_log");

      // I-space write and fault log
      cfg_write(0, 32'h2);
      run_access("ispace", 1'b1, 32'h100, 0, 1'b0, 32'h0, f);
      cfg_read(2, d); check("ispace_faddr", d, 32'h100);
      cfg_read(3, d); check("ispace_finfo", d, 32'h0001_0003);
      check("ispace_irq", {31'd0, fault_irq}, 32'd1);
      cfg_write(0, 32'h2);
      run_access("log_a", 1'b1, 32'h10, 0, 1'b0, 32'h0, f);
      run_access("log_b", 1'b1, 32'h20, 0, 1'b0, 32'h0, f);
      run_access("log_c", 1'b1, 32'h30, 0, 1'b0, 32'h0, f);
      cfg_read(2, d); check("log3_faddr", d, 32'h10);
      cfg_read(3, d); check("log3_finfo", d, 32'h0003_0003);
      run_access("log_d", 1'b1, 32'h40, 0, 1'b0, 32'h0, f);
      run_access("log_e", 1'b1, 32'h50, 0, 1'b0, 32'h0, f);
      cfg_read(3, d); check("log5_sat", d, 32'h0003_0003);

      // CLR and a blocked request landing on the same edge
      @(negedge clk);
      cfg_en = 1; cfg_we = 1; cfg_addr = 6'd0; cfg_wdata = 32'h2;
      dma_req = 1; dma_we = 1; dma_addr = 32'h200; dma_be = 4'hF;
      @(negedge clk);
      cfg_en = 0; cfg_we = 0;
      check("clrev_done", {30'd0, dma_done, dma_fault}, 32'd3);
      @(negedge clk);
      dma_req = 0;
      model_clear(); model_fault(32'h200, 1'b1, 1'b0);
      cfg_read(3, d); check("clrev_finfo", d, 32'h0001_0003);
      cfg_read(2, d); check("clrev_faddr", d, 32'h200);

      // bus error on a forwarded read
      cfg_write(0, 32'h2);
      run_access("buserr", 1'b0, 32'h2000, 3, 1'b1, 32'h5555_AAAA, f);
      cfg_read(3, d); check("buserr_finfo", d, 32'h0001_0001);
      cfg_read(2, d); check("buserr_faddr", d, 32'h2000);

`ifdef HARVOS_DMA_FW_TIMEOUT_EN
      cfg_write(0, 32'h2);
      run_access("timeout", 1'b0, 32'h2004, -1, 1'b0, 32'h0, f);
      cfg_read(3, d); check("timeout_finfo", d, 32'h0001_0005);
`endif

      // stray response while idle
      @(negedge clk); m_rvalid = 1; m_rdata = 32'h1111_2222;
      @(negedge clk); m_rvalid = 0;
      check("stray_rvalid", {30'd0, dma_done, fw_req}, 32'd0);
      @(negedge clk);
      check("stray_rvalid2", {31'd0, dma_done}, 32'd0);

      // randomized configuration and traffic against the model
      cfg_write(0, 32'h2);
      for (r = 0; r < NREG; r++) begin
         k = $urandom_range(4, 12);
         msk = (32'd1 << k) - 32'd1;
         cfg_write(4 + 3 * r, $urandom & ~msk);
         cfg_write(5 + 3 * r, msk);
         cfg_write(6 + 3 * r, 32'($urandom_range(0, 7)));
      end
      cfg_write(1, 32'($urandom_range(0, 32'h8000)));
      for (int i = 0; i < 60; i++) begin
         sel = $urandom_range(0, 3);
         r = $urandom_range(0, NREG - 1);
         if (sel == 0)      a = m_base[r] | ($urandom & m_mask[r]);
         else if (sel == 1) a = 32'($urandom_range(0, 32'h9000));
         else               a = $urandom;
         run_access($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a,
                    $urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom, f);
      end
      check_log("rnd_log");

      // lock
      for (r = 0; r < NREG; r++) cfg_write(6 + 3 * r, 32'h0);
      cfg_write(1, 32'h4000);
      cfg_write(0, 32'h1);
      cfg_read(0, d); check("lock_ctrl", d, 32'h1);
      cfg_write(5, 32'h0);
      cfg_read(5, d); check("lock_mask0", d, m_mask[0]);
      cfg_write(1, 32'h0);
      cfg_read(1, d); check("lock_rom", d, 32'h4000);
      run_access("lock_fault", 1'b1, 32'h100, 0, 1'b0, 32'h0, f);
      check("lock_irq", {31'd0, fault_irq}, 32'd1);
      @(negedge clk);
      cfg_en = 1; cfg_we = 1; cfg_addr = 6'd0; cfg_wdata = 32'h2;
      check("lock_irq_pre", {31'd0, fault_irq}, 32'd1);
      @(negedge clk);
      cfg_en = 0; cfg_we = 0;
      check("lock_clr_irq", {31'd0, fault_irq}, 32'd0);
      model_clear();
      check_log("lock_clr");

      // reset while a forwarded read waits for its response
      @(negedge clk);
      dma_req = 1; dma_we = 0; dma_addr = 32'h3000; dma_be = 4'hF;
      seen = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (fw_req) seen = 1;
      end
      check("rstw_fwd", {31'd0, seen}, 32'd1);
      rst_n = 0; dma_req = 0; m_rvalid = 1; m_rdata = 32'h7777_7777;
      seen = 0;
      repeat (3) begin @(negedge clk); seen |= dma_done; end
      m_rvalid = 0; rst_n = 1;
      repeat (3) begin @(negedge clk); seen |= dma_done; end
      check("rstw_nodone", {31'd0, seen}, 32'd0);
      check("rstw_ctl", {23'd0, dma_done, dma_fault, fw_req, fw_we, fw_be, fault_irq}, 32'd0);
      check("rstw_fwaddr", fw_addr, 32'd0);
      model_reset();
      cfg_read(0, d); check("rstw_lock", d, 32'd0);
      cfg_read(1, d); check("rstw_rom", d, 32'h4000);
      cfg_read(5, d); check("rstw_mask0", d, 32'hFFFF_FFFF);
      cfg_read(3, d); check("rstw_finfo", d, 32'd0);
      run_access("post_rst", 1'b0, 32'h3000, 1, 1'b0, 32'hABCD_0123, f);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/harvos_dma_firewall_mr.md
Name: harvos_dma_firewall_mr

Overview:
- Multi-region DMA bus firewall between one DMA master and the HarvOS dmem fabric; next generation of the single-region firewall.
- Blocks DMA writes to I-space. Checks NREG programmable base/mask regions, each with independent read-block and write-block bits.
- Logs the first blocked access (address, direction) plus a saturating fault count, and raises a level interrupt.
- Single-outstanding forwarding: one request in flight, response proxied back to the DMA.

Parameters:
- NREG, 4, number of protected regions (1..16).
- ROM_BYTES, 16384, reset value of the I-space limit register.
- CNT_W, 16, width of the saturating fault counter (1..16).
- TIMEOUT, 255, response-wait cycle limit; used only with HARVOS_DMA_FW_TIMEOUT_EN (1..65535).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_en  in  1  config access strobe
- cfg_we  in  1  config write
- cfg_addr  in  6  config word index
- cfg_wdata  in  32  config write data
- cfg_rdata  out  32  config read data (combinational)
- dma_req  in  1  DMA request; held until dma_done
- dma_we  in  1  DMA write
- dma_be  in  4  byte enables
- dma_addr  in  32  byte address
- dma_wdata  in  32  write data
- dma_rdata  out  32  read data, valid with dma_done
- dma_done  out  1  one-cycle completion pulse
- dma_fault  out  1  fault qualifier, valid with dma_done
- fw_req  out  1  forwarded request, one-cycle pulse
- fw_we  out  1  forwarded write
- fw_be  out  4  forwarded byte enables
- fw_addr  out  32  forwarded address
- fw_wdata  out  32  forwarded write data
- m_rdata  in  32  bus read data
- m_rvalid  in  1  bus response valid
- m_fault  in  1  bus error
- fault_irq  out  1  level interrupt, equals FAULT_INFO.valid

Behaviour:
- Reset values:
  - All outputs 0.
  - rom_q = ROM_BYTES. All regions disabled: base 0, mask FFFF_FFFF, ctrl 0.
  - Lock 0. Fault log cleared.
  - FSM in IDLE.
- Config map (word index):
  - 0 CONTROL: bit0 LOCK (set-only, sticky); bit1 CLR (write 1 clears fault log; honoured even when locked).
  - 1 ROM_LIMIT.
  - 2 FAULT_ADDR (RO).
  - 3 FAULT_INFO (RO): bit0 valid, bit1 we, bits[31:16] count, zero-extended from CNT_W.
  - 4+3i BASE_i, 5+3i MASK_i, 6+3i CTRL_i, where CTRL bits are [0] en, [1] block_rd, [2] block_wr.
- Config writes:
  - All writes except CONTROL.CLR are ignored once LOCK=1.
  - Unmapped indices read 0; writes to them are ignored.
- Block decision (combinational on dma_* in IDLE):
  - hit_i = en_i & ((addr & ~mask_i) == base_i).
  - block = (we & addr<rom_q) | OR_i(hit_i & (we ? block_wr_i : block_rd_i)).
  - Unsigned compare. Region order is irrelevant.
- FSM states IDLE, WAIT, FAULT:
  - IDLE & dma_req & block -> FAULT. No fw_req.
  - IDLE & dma_req & !block -> fw_req=1 for exactly one cycle; fw_* come from registers captured that cycle; -> WAIT.
  - WAIT & m_rvalid -> dma_done=1, dma_fault=m_fault, dma_rdata = we_q ? 0 : m_rdata; -> IDLE.
  - FAULT -> dma_done=1, dma_fault=1, dma_rdata=0; -> IDLE.
- dma_req is sampled only in IDLE.
- Latency: allowed access is bus latency + 1 cycle; blocked access completes with dma_done 1 cycle after the request.
- m_rvalid outside WAIT is ignored.
- Fault log:
  - Updated on entry to FAULT, and on a WAIT completion with m_fault=1.
  - If valid=0: capture addr and we, set valid.
  - Count increments on every fault and saturates at all-ones.
  - Fault event and CLR in the same cycle: the log clears, then the event is recorded (valid=1, count=1).
- Reset asserted mid-transaction: FSM returns to IDLE immediately. Any pending response is dropped and no dma_done is issued.

Optional Feature:
- Macro HARVOS_DMA_FW_TIMEOUT_EN.
- Defined:
  - WAIT runs a cycle counter. If TIMEOUT cycles pass without m_rvalid, the FSM goes to FAULT: done+fault, logged like any other fault, with FAULT_INFO bit2 = timeout.
  - A later stray m_rvalid is ignored.
- Undefined: WAIT holds indefinitely, bit2 reads 0, and no counter logic exists.

Decomposition:
- Package harvos_dma_fw_pkg holds:
  - FSM state encoding.
  - Config index constants: CTRL, ROM, FADDR, FINFO, REGION_BASE=4, REGION_STRIDE=3.
  - CTRL bit positions.
- One sub-module, harvos_dma_fw_region: per-region registers plus hit/block logic, instantiated NREG times via generate.

Test Plan:
- I-space write: rom=0x4000, write 0x100 -> dma_done+dma_fault after 1 cycle, fw_req never asserts, FAULT_ADDR=0x100, count=1, fault_irq=1. Read 0x100 -> forwarded.
- Region write-only block: region 2 base 0x8000_0000, mask 0xFFF, ctrl=0b101. Read 0x8000_0010 forwarded and returns m_rdata 0xDEADBEEF; write 0x8000_0010 faults.
- Lock: set LOCK, write MASK_0=0 -> readback unchanged. CLR still clears the log; fault_irq drops the next cycle.
- Fault log: three blocked writes at 0x10, 0x20, 0x30 -> FAULT_ADDR=0x10, count=3. With CNT_W=2, five faults -> count=3.
- Bus error, then reset: forwarded read with m_fault=1 after 4 cycles -> dma_fault=1 and fault logged. Assert rst_n low while in WAIT -> no dma_done, all registers back to reset values.
- Timeout (macro on, TIMEOUT=8): m_rvalid withheld -> done+fault exactly 8 cycles after entering WAIT, FAULT_INFO bit2=1.
